// File: rtl/sb_tx_scheduler.sv
// -----------------------------------------------------------------------------
// sb_tx_scheduler
//
// Purpose:
//   Shares the single sideband transmit channel between three requesters:
//   the LT transaction generator, the AT response generator and the AT command
//   generator. It grants one requester at a time, holds the grant until the
//   serializer reports end of transaction, and forces an idle gap between
//   transactions. It also tracks the single outstanding AT command, times out
//   a missing response, and drives a bounded retry sequence.
//
// Ports:
//   sb_clk          in   sideband clock
//   rst             in   asynchronous active-low reset
//   enable          in   link connected; low aborts everything on the next edge
//   lt_req          in   LT generator requests the channel
//   at_rsp_req      in   AT response generator requests the channel
//   at_cmd_req      in   AT command generator requests the channel
//   tx_done         in   serializer pulse: last symbol of the transaction sent
//   at_rsp_rcvd     in   pulse: valid AT response received
//   lt_gnt          out  grant to the LT generator
//   at_rsp_gnt      out  grant to the AT response generator
//   at_cmd_gnt      out  grant to the AT command generator
//   gnt_id          out  0 none, 1 LT, 2 AT response, 3 AT command
//   busy            out  high while in GRANT or GAP
//   cmd_outstanding out  AT command sent, response pending
//   cmd_retry       out  pulse: requester must resend the AT command
//   cmd_timeout_err out  pulse: retries exhausted
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module sb_tx_scheduler #(
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned RSP_TIMEOUT = 1000,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned TO_W        = 10
) (
    input  logic       sb_clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       lt_req,
    input  logic       at_rsp_req,
    input  logic       at_cmd_req,
    input  logic       tx_done,
    input  logic       at_rsp_rcvd,
    output logic       lt_gnt,
    output logic       at_rsp_gnt,
    output logic       at_cmd_gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       cmd_outstanding,
    output logic       cmd_retry,
    output logic       cmd_timeout_err
);

    // Gap counter runs 0..GAP_CYCLES-1; keep at least one bit.
    localparam int unsigned GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    // Retry counter must hold the value MAX_RETRY itself.
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(RSP_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM  = RETRY_W'(MAX_RETRY);

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_LT   = 2'd1;
    localparam logic [1:0] GNT_RSP  = 2'd2;
    localparam logic [1:0] GNT_CMD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             state;
    logic [GAP_W-1:0]   gap_cnt;
    logic [TO_W-1:0]    rsp_timer;
    logic [RETRY_W-1:0] retry_cnt;

    // The command's own tx_done opens the response window.
    logic cmd_sent_c;
    assign cmd_sent_c = (state == ST_GRANT) && tx_done && (gnt_id == GNT_CMD);

    // Arbiter FSM plus response tracking; enable low behaves like a
    // synchronous reset that also swallows any pending timeout pulse.
    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            gap_cnt         <= '0;
            rsp_timer       <= '0;
            retry_cnt       <= '0;
            lt_gnt          <= 1'b0;
            at_rsp_gnt      <= 1'b0;
            at_cmd_gnt      <= 1'b0;
            gnt_id          <= GNT_NONE;
            busy            <= 1'b0;
            cmd_outstanding <= 1'b0;
            cmd_retry       <= 1'b0;
            cmd_timeout_err <= 1'b0;
        end else if (!enable) begin
            state           <= ST_IDLE;
            gap_cnt         <= '0;
            rsp_timer       <= '0;
            retry_cnt       <= '0;
            lt_gnt          <= 1'b0;
            at_rsp_gnt      <= 1'b0;
            at_cmd_gnt      <= 1'b0;
            gnt_id          <= GNT_NONE;
            busy            <= 1'b0;
            cmd_outstanding <= 1'b0;
            cmd_retry       <= 1'b0;
            cmd_timeout_err <= 1'b0;
        end else begin
            // Pulses default low every cycle.
            cmd_retry       <= 1'b0;
            cmd_timeout_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // Fixed priority LT > AT response > AT command; a new
                    // command waits until the previous one is resolved.
                    if (lt_req) begin
                        lt_gnt <= 1'b1;
                        gnt_id <= GNT_LT;
                        busy   <= 1'b1;
                        state  <= ST_GRANT;
                    end else if (at_rsp_req) begin
                        at_rsp_gnt <= 1'b1;
                        gnt_id     <= GNT_RSP;
                        busy       <= 1'b1;
                        state      <= ST_GRANT;
                    end else if (at_cmd_req && !cmd_outstanding) begin
                        at_cmd_gnt <= 1'b1;
                        gnt_id     <= GNT_CMD;
                        busy       <= 1'b1;
                        state      <= ST_GRANT;
                    end
                end

                ST_GRANT: begin
                    // Grant is held regardless of the request level.
                    if (tx_done) begin
                        lt_gnt     <= 1'b0;
                        at_rsp_gnt <= 1'b0;
                        at_cmd_gnt <= 1'b0;
                        gnt_id     <= GNT_NONE;
                        gap_cnt    <= '0;
                        state      <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Response window: a received response always beats a timeout
            // landing in the same cycle.
            if (cmd_sent_c) begin
                cmd_outstanding <= 1'b1;
                rsp_timer       <= '0;
            end else if (cmd_outstanding) begin
                if (at_rsp_rcvd) begin
                    cmd_outstanding <= 1'b0;
                    rsp_timer       <= '0;
                    retry_cnt       <= '0;
                end else if (rsp_timer == TO_LAST) begin
                    cmd_outstanding <= 1'b0;
                    rsp_timer       <= '0;
                    if (retry_cnt < RETRY_LIM) begin
                        cmd_retry <= 1'b1;
                        retry_cnt <= retry_cnt + RETRY_W'(1);
                    end else begin
                        cmd_timeout_err <= 1'b1;
                        retry_cnt       <= '0;
                    end
                end else begin
                    rsp_timer <= rsp_timer + TO_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sb_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sb_tx_scheduler
//
// Directed bench for sb_tx_scheduler. u_dut runs a short response timeout
// (16 cycles); u_long keeps the default 1000-cycle timeout for the long
// response-latency case. Both share the request/handshake inputs and have
// separate enables, so only one of them reacts at a time.
// Inputs change and outputs are sampled on the falling edge of sb_clk.
// -----------------------------------------------------------------------------
module tb_sb_tx_scheduler;

    logic       sb_clk;
    logic       rst;
    logic       en;
    logic       en_l;
    logic       lt_req;
    logic       at_rsp_req;
    logic       at_cmd_req;
    logic       tx_done;
    logic       at_rsp_rcvd;

    logic       lt_gnt, at_rsp_gnt, at_cmd_gnt;
    logic [1:0] gnt_id;
    logic       busy, cmd_outstanding, cmd_retry, cmd_timeout_err;

    logic       l_lt_gnt, l_at_rsp_gnt, l_at_cmd_gnt;
    logic [1:0] l_gnt_id;
    logic       l_busy, l_cmd_outstanding, l_cmd_retry, l_cmd_timeout_err;

    int n_cmp;
    int n_err;

    sb_tx_scheduler #(
        .GAP_CYCLES (2),
        .RSP_TIMEOUT(16),
        .MAX_RETRY  (3),
        .TO_W       (5)
    ) u_dut (
        .sb_clk         (sb_clk),
        .rst            (rst),
        .enable         (en),
        .lt_req         (lt_req),
        .at_rsp_req     (at_rsp_req),
        .at_cmd_req     (at_cmd_req),
        .tx_done        (tx_done),
        .at_rsp_rcvd    (at_rsp_rcvd),
        .lt_gnt         (lt_gnt),
        .at_rsp_gnt     (at_rsp_gnt),
        .at_cmd_gnt     (at_cmd_gnt),
        .gnt_id         (gnt_id),
        .busy           (busy),
        .cmd_outstanding(cmd_outstanding),
        .cmd_retry      (cmd_retry),
        .cmd_timeout_err(cmd_timeout_err)
    );

    sb_tx_scheduler u_long (
        .sb_clk         (sb_clk),
        .rst            (rst),
        .enable         (en_l),
        .lt_req         (lt_req),
        .at_rsp_req     (at_rsp_req),
        .at_cmd_req     (at_cmd_req),
        .tx_done        (tx_done),
        .at_rsp_rcvd    (at_rsp_rcvd),
        .lt_gnt         (l_lt_gnt),
        .at_rsp_gnt     (l_at_rsp_gnt),
        .at_cmd_gnt     (l_at_cmd_gnt),
        .gnt_id         (l_gnt_id),
        .busy           (l_busy),
        .cmd_outstanding(l_cmd_outstanding),
        .cmd_retry      (l_cmd_retry),
        .cmd_timeout_err(l_cmd_timeout_err)
    );

    initial sb_clk = 1'b0;
    always #5 sb_clk = ~sb_clk;

    task automatic tick();
        @(negedge sb_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Grant vector as {lt, rsp, cmd} for compact checks.
    function automatic logic [2:0] gnts();
        return {lt_gnt, at_rsp_gnt, at_cmd_gnt};
    endfunction

    // tx_done during a grant, then the two gap cycles and the return to IDLE.
    task automatic finish_txn(input string tag);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk({tag, "_drop_gnts"}, 32'(gnts()), 32'h0);
        chk({tag, "_drop_id"},   32'(gnt_id), 32'h0);
        chk({tag, "_gap0_busy"}, 32'(busy),   32'h1);
        tick();
        chk({tag, "_gap1_busy"}, 32'(busy),   32'h1);
        chk({tag, "_gap1_gnts"}, 32'(gnts()), 32'h0);
        tick();
        chk({tag, "_idle_busy"}, 32'(busy),   32'h0);
        chk({tag, "_idle_id"},   32'(gnt_id), 32'h0);
    endtask

    // Command granted, sent, no response: expect retry (or error) 16 cycles
    // after the command's tx_done edge.
    task automatic cmd_round(input string tag, input logic exp_err);
        at_cmd_req = 1'b1;
        tick();
        chk({tag, "_cmd_gnt"}, 32'(gnts()), 32'h1);
        chk({tag, "_cmd_id"},  32'(gnt_id), 32'h3);
        at_cmd_req = 1'b0;
        finish_txn(tag);
        chk({tag, "_outst"}, 32'(cmd_outstanding), 32'h1);
        repeat (13) tick();
        chk({tag, "_outst15"}, 32'(cmd_outstanding), 32'h1);
        chk({tag, "_retry15"}, 32'(cmd_retry),       32'h0);
        tick();
        chk({tag, "_retry16"}, 32'(cmd_retry),       32'(!exp_err));
        chk({tag, "_err16"},   32'(cmd_timeout_err), 32'(exp_err));
        chk({tag, "_outst16"}, 32'(cmd_outstanding), 32'h0);
        tick();
        chk({tag, "_retry17"}, 32'(cmd_retry),       32'h0);
        chk({tag, "_err17"},   32'(cmd_timeout_err), 32'h0);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b0;
        en          = 1'b0;
        en_l        = 1'b0;
        lt_req      = 1'b0;
        at_rsp_req  = 1'b0;
        at_cmd_req  = 1'b0;
        tx_done     = 1'b0;
        at_rsp_rcvd = 1'b0;

        // Reset values.
        tick();
        tick();
        chk("rst_gnts",  32'(gnts()),          32'h0);
        chk("rst_id",    32'(gnt_id),          32'h0);
        chk("rst_busy",  32'(busy),            32'h0);
        chk("rst_outst", 32'(cmd_outstanding), 32'h0);
        chk("rst_retry", 32'(cmd_retry),       32'h0);
        chk("rst_err",   32'(cmd_timeout_err), 32'h0);
        rst = 1'b1;
        en  = 1'b1;
        tick();

        // All three request together: LT, then AT response, then AT command.
        lt_req     = 1'b1;
        at_rsp_req = 1'b1;
        at_cmd_req = 1'b1;
        tick();
        chk("pri_lt_gnts", 32'(gnts()), 32'h4);
        chk("pri_lt_id",   32'(gnt_id), 32'h1);
        chk("pri_lt_busy", 32'(busy),   32'h1);
        lt_req = 1'b0;
        repeat (3) tick();
        chk("hold_lt_gnts", 32'(gnts()), 32'h4);
        chk("hold_lt_id",   32'(gnt_id), 32'h1);
        finish_txn("lt1");
        tick();
        chk("pri_rsp_gnts", 32'(gnts()), 32'h2);
        chk("pri_rsp_id",   32'(gnt_id), 32'h2);
        at_rsp_req = 1'b0;
        finish_txn("rsp1");
        tick();
        chk("pri_cmd_gnts", 32'(gnts()), 32'h1);
        chk("pri_cmd_id",   32'(gnt_id), 32'h3);
        at_cmd_req = 1'b0;
        finish_txn("cmd1");
        chk("cmd1_outst", 32'(cmd_outstanding), 32'h1);

        // Early response clears the outstanding command.
        repeat (3) tick();
        at_rsp_rcvd = 1'b1;
        tick();
        at_rsp_rcvd = 1'b0;
        chk("early_rsp_outst", 32'(cmd_outstanding), 32'h0);
        chk("early_rsp_retry", 32'(cmd_retry),       32'h0);

        // Three retries, then the error, then the retry count starts over.
        cmd_round("r1", 1'b0);
        cmd_round("r2", 1'b0);
        cmd_round("r3", 1'b0);
        cmd_round("r4", 1'b1);
        cmd_round("r5", 1'b0);

        // Response and timeout in the same cycle: response wins. A new
        // command request is held off while the first is outstanding.
        at_cmd_req = 1'b1;
        tick();
        chk("col_cmd_gnts", 32'(gnts()), 32'h1);
        finish_txn("col");
        repeat (13) tick();
        chk("col_blocked_gnts", 32'(gnts()), 32'h0);
        chk("col_blocked_id",   32'(gnt_id), 32'h0);
        at_rsp_rcvd = 1'b1;
        tick();
        at_rsp_rcvd = 1'b0;
        chk("col_retry", 32'(cmd_retry),       32'h0);
        chk("col_err",   32'(cmd_timeout_err), 32'h0);
        chk("col_outst", 32'(cmd_outstanding), 32'h0);
        chk("col_gnts",  32'(gnts()),          32'h0);
        tick();
        chk("col_retry2",   32'(cmd_retry), 32'h0);
        chk("col_regnt",    32'(gnts()),    32'h1);
        chk("col_regnt_id", 32'(gnt_id),    32'h3);
        at_cmd_req = 1'b0;

        // Disconnect while the AT response holds the channel and a command
        // is outstanding.
        at_rsp_req = 1'b1;
        finish_txn("dis");
        chk("dis_outst_pre", 32'(cmd_outstanding), 32'h1);
        tick();
        chk("dis_rsp_gnts", 32'(gnts()), 32'h2);
        at_rsp_req = 1'b0;
        lt_req     = 1'b1;
        en         = 1'b0;
        tick();
        chk("dis_gnts",  32'(gnts()),          32'h0);
        chk("dis_id",    32'(gnt_id),          32'h0);
        chk("dis_busy",  32'(busy),            32'h0);
        chk("dis_outst", 32'(cmd_outstanding), 32'h0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("dis_quiet", 32'({cmd_retry, cmd_timeout_err, lt_gnt}), 32'h0);
        end
        en = 1'b1;
        tick();
        chk("reen_lt_gnts", 32'(gnts()), 32'h4);
        chk("reen_lt_id",   32'(gnt_id), 32'h1);
        lt_req = 1'b0;
        finish_txn("lt2");

        // Stray tx_done in IDLE changes nothing.
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("stray_id",   32'(gnt_id), 32'h0);
        chk("stray_busy", 32'(busy),   32'h0);
        tick();
        chk("stray_busy2", 32'(busy), 32'h0);

        // Long timeout instance: response 50 cycles after the command.
        en   = 1'b0;
        en_l = 1'b1;
        tick();
        at_cmd_req = 1'b1;
        tick();
        chk("long_cmd_gnt", 32'(l_at_cmd_gnt), 32'h1);
        chk("long_cmd_id",  32'(l_gnt_id),     32'h3);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("long_outst0", 32'(l_cmd_outstanding), 32'h1);
        repeat (48) tick();
        chk("long_outst49",   32'(l_cmd_outstanding), 32'h1);
        chk("long_blocked",   32'(l_at_cmd_gnt),      32'h0);
        chk("long_retry49",   32'(l_cmd_retry),       32'h0);
        at_rsp_rcvd = 1'b1;
        tick();
        at_rsp_rcvd = 1'b0;
        chk("long_outst50", 32'(l_cmd_outstanding), 32'h0);
        chk("long_retry50", 32'(l_cmd_retry),       32'h0);
        chk("long_gnt50",   32'(l_at_cmd_gnt),      32'h0);
        tick();
        chk("long_regnt",    32'(l_at_cmd_gnt), 32'h1);
        chk("long_regnt_id", 32'(l_gnt_id),     32'h3);
        at_cmd_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
